// File: rtl/bus_mem_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module   : bus_mem_ctrl_if
// Brief    : CPU-side request/response and ROM preload signals of the memory bus
// Revision : 1.0
// ============================================================================
interface bus_mem_ctrl_if #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 8
);
    logic [ADDR_W-1:0] addr_bus;
    logic              read_en;
    logic              write_en;
    logic              ready;
    logic              bus_err;
    logic              rom_load_en;
    logic [ADDR_W-1:0] rom_load_addr;
    logic [DATA_W-1:0] rom_load_data;

    modport master (
        output addr_bus, read_en, write_en,
        output rom_load_en, rom_load_addr, rom_load_data,
        input  ready, bus_err
    );

    modport slave (
        input  addr_bus, read_en, write_en,
        input  rom_load_en, rom_load_addr, rom_load_data,
        output ready, bus_err
    );
endinterface
`default_nettype wire

// File: rtl/bus_mem_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : bus_mem_ctrl
// Brief    : ROM/RAM bus slave with address decode, wait states and ROM preload
// Revision : 1.0
// ============================================================================
module bus_mem_ctrl #(
    parameter int                ADDR_W      = 16,
    parameter int                DATA_W      = 8,
    parameter logic [ADDR_W-1:0] ROM_BASE    = 'h0000,
    parameter int                ROM_DEPTH   = 256,
    parameter logic [ADDR_W-1:0] RAM_BASE    = 'h0100,
    parameter int                RAM_DEPTH   = 256,
    parameter int                WAIT_STATES = 1
) (
    input  wire                clk,
    input  wire                reset,
    bus_mem_ctrl_if.slave      bus,
    inout  wire [DATA_W-1:0]   data_bus
);
    localparam int c_ROM_AW = (ROM_DEPTH > 1) ? $clog2(ROM_DEPTH) : 1;
    localparam int c_RAM_AW = (RAM_DEPTH > 1) ? $clog2(RAM_DEPTH) : 1;
    localparam int c_CNT_W  = (WAIT_STATES > 1) ? $clog2(WAIT_STATES + 1) : 1;

    // Region ends carry one extra bit so a region touching the top of the map cannot wrap
    localparam logic [ADDR_W:0]  c_ROM_END   = {1'b0, ROM_BASE} + (ADDR_W+1)'(ROM_DEPTH);
    localparam logic [ADDR_W:0]  c_RAM_END   = {1'b0, RAM_BASE} + (ADDR_W+1)'(RAM_DEPTH);
    localparam logic [ADDR_W:0]  c_ROM_LIMIT = (ADDR_W+1)'(ROM_DEPTH);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);
    localparam logic [c_CNT_W-1:0] c_CNT_INIT = c_CNT_W'(WAIT_STATES);
    localparam bit               c_ZERO_WAIT = (WAIT_STATES == 0);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_RESP = 2'd2
    } state_t;

    state_t              r_state;
    logic [c_CNT_W-1:0]  r_cnt;
    logic [ADDR_W-1:0]   r_addr;
    logic                r_rd;
    logic [DATA_W-1:0]   r_wdata;
    logic [DATA_W-1:0]   r_rdata;
    logic                r_ready;
    logic                r_err;
    logic                r_drive;

    logic [DATA_W-1:0]   r_rom [ROM_DEPTH];
    logic [DATA_W-1:0]   r_ram [RAM_DEPTH];

    logic [ADDR_W-1:0]   w_acc_addr;
    logic                w_acc_rd;
    logic [DATA_W-1:0]   w_acc_wdata;
    logic                w_req;
    logic                w_illegal;
    logic                w_hit_rom;
    logic                w_hit_ram;
    logic [c_ROM_AW-1:0] w_rom_idx;
    logic [c_RAM_AW-1:0] w_ram_idx;
    logic                w_access;
    logic                w_err;
    logic [DATA_W-1:0]   w_rdata;

    assign w_req     = bus.read_en ^ bus.write_en;
    assign w_illegal = bus.read_en & bus.write_en;

    // With zero wait states the access uses the live request rather than the captured one
    always_comb begin
        w_acc_addr  = r_addr;
        w_acc_rd    = r_rd;
        w_acc_wdata = r_wdata;
        if (r_state == S_IDLE) begin
            w_acc_addr  = bus.addr_bus;
            w_acc_rd    = bus.read_en;
            w_acc_wdata = data_bus;
        end
    end

    assign w_hit_rom = (w_acc_addr >= ROM_BASE) && ({1'b0, w_acc_addr} < c_ROM_END);
    assign w_hit_ram = !w_hit_rom && (w_acc_addr >= RAM_BASE) && ({1'b0, w_acc_addr} < c_RAM_END);
    assign w_rom_idx = c_ROM_AW'(w_acc_addr - ROM_BASE);
    assign w_ram_idx = c_RAM_AW'(w_acc_addr - RAM_BASE);

    assign w_access = reset &&
                      (((r_state == S_IDLE) && w_req && c_ZERO_WAIT) ||
                       ((r_state == S_WAIT) && (r_cnt == c_CNT_ONE)));

    assign w_err   = w_acc_rd ? !(w_hit_rom || w_hit_ram) : !w_hit_ram;
    assign w_rdata = w_hit_rom ? r_rom[w_rom_idx] :
                     w_hit_ram ? r_ram[w_ram_idx] : {DATA_W{1'b1}};

    always_ff @(posedge clk) begin
        if (bus.rom_load_en && ({1'b0, bus.rom_load_addr} < c_ROM_LIMIT)) begin
            r_rom[c_ROM_AW'(bus.rom_load_addr)] <= bus.rom_load_data;
        end
    end

    always_ff @(posedge clk) begin
        if (w_access && !w_acc_rd && w_hit_ram) begin
            r_ram[w_ram_idx] <= w_acc_wdata;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= S_IDLE;
            r_cnt   <= '0;
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_drive <= 1'b0;
        end else begin
            r_ready <= 1'b0;
            r_err   <= 1'b0;
            r_drive <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (w_illegal) begin
                        r_rd    <= 1'b0;
                        r_state <= S_RESP;
                        r_ready <= 1'b1;
                        r_err   <= 1'b1;
                    end else if (w_req) begin
                        r_addr  <= bus.addr_bus;
                        r_rd    <= bus.read_en;
                        r_wdata <= data_bus;
                        r_cnt   <= c_CNT_INIT;
                        r_state <= S_WAIT;
                    end
                end
                S_WAIT: begin
                    r_cnt <= r_cnt - c_CNT_ONE;
                end
                S_RESP: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
            // Completion overrides the plain state step (covers the zero-wait IDLE case too)
            if (w_access) begin
                r_state <= S_RESP;
                r_ready <= 1'b1;
                r_err   <= w_err;
                r_drive <= w_acc_rd;
                if (w_acc_rd) begin
                    r_rdata <= w_rdata;
                end
            end
        end
    end

    assign bus.ready   = r_ready;
    assign bus.bus_err = r_err;
    assign data_bus    = r_drive ? r_rdata : {DATA_W{1'bz}};

endmodule
`default_nettype wire
